// File: rtl/register_file_multi_way_mw_multi_port_read.sv
// rtl/register_file_multi_way_mw_multi_port_read.sv - multi-way, multi-write/multi-read register file with valid tracking
//
// Purpose:
//   Flip-flop register file with NB_WAYS ways and NUM_WORDS = 2**ADDR_WIDTH words per way.
//   It has N_WRITE write ports, each with a way mask, and N_READ registered-address read ports.
//   Writes and invalidates first land in a one-cycle staging register, then commit to the array
//   at the following edge.
//   When two write ports hit the same (way, addr), the lower port index wins.
//   When a write and an invalidate commit to the same word on the same edge, the write wins.
//
// Optional feature (macro SCM_WRITE_BYPASS_EN):
//   When defined, staged writes and invalidates are forwarded to matching read ports during
//   the staging cycle, which cuts read-after-write latency to one cycle.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   ReadEnable   [N_READ]                        per-port read request (loads the address register)
//   ReadAddr     [N_READ][ADDR_WIDTH]            read address
//   ReadData     [NB_WAYS][N_READ][DATA_WIDTH]   word per way per port, 0 when the word is invalid
//   ReadValid    [NB_WAYS][N_READ]               valid flag of the addressed word
//   WriteEnable  [N_WRITE]                       per-port write request
//   WriteWay     [N_WRITE][NB_WAYS]              way mask per write port (multi-hot allowed)
//   WriteAddr    [N_WRITE][ADDR_WIDTH]           write address
//   WriteData    [N_WRITE][DATA_WIDTH]           write data
//   InvEnable    invalidate request
//   InvWay       [NB_WAYS]                       ways to invalidate
//   InvAddr      [ADDR_WIDTH]                    word to invalidate

module register_file_multi_way_mw_multi_port_read #(
  parameter int NB_WAYS    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int N_READ     = 2,
  parameter int N_WRITE    = 2
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [N_READ-1:0]                                ReadEnable,
  input  logic [N_READ-1:0][ADDR_WIDTH-1:0]                ReadAddr,
  output logic [NB_WAYS-1:0][N_READ-1:0][DATA_WIDTH-1:0]   ReadData,
  output logic [NB_WAYS-1:0][N_READ-1:0]                   ReadValid,
  input  logic [N_WRITE-1:0]                               WriteEnable,
  input  logic [N_WRITE-1:0][NB_WAYS-1:0]                  WriteWay,
  input  logic [N_WRITE-1:0][ADDR_WIDTH-1:0]               WriteAddr,
  input  logic [N_WRITE-1:0][DATA_WIDTH-1:0]               WriteData,
  input  logic                                             InvEnable,
  input  logic [NB_WAYS-1:0]                               InvWay,
  input  logic [ADDR_WIDTH-1:0]                            InvAddr
);

  localparam int NUM_WORDS = 2 ** ADDR_WIDTH;

  // Array storage: data is never reset, only the valid flags are.
  logic [DATA_WIDTH-1:0]                  mem [NB_WAYS][NUM_WORDS];
  logic [NB_WAYS-1:0][NUM_WORDS-1:0]      valid_q;

  // Registered read addresses.
  logic [N_READ-1:0][ADDR_WIDTH-1:0]      raddr_q;

  // Write staging register, one slot per port.
  logic [N_WRITE-1:0]                     stage_en;
  logic [N_WRITE-1:0][ADDR_WIDTH-1:0]     stage_addr;
  logic [N_WRITE-1:0][NB_WAYS-1:0]        stage_way;
  logic [N_WRITE-1:0][DATA_WIDTH-1:0]     stage_data;

  // Invalidate staging register.
  logic                                   inv_en;
  logic [NB_WAYS-1:0]                     inv_way;
  logic [ADDR_WIDTH-1:0]                  inv_addr;

  // ------------------------------------------------------------------
  // Staging: the enables are reset. The payload is captured only on a request.
  // A request with an empty way mask is dropped here so it can never commit.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_en <= '0;
      inv_en   <= 1'b0;
    end else begin
      for (int p = 0; p < N_WRITE; p++) begin
        stage_en[p] <= WriteEnable[p] & (|WriteWay[p]);
      end
      inv_en <= InvEnable & (|InvWay);
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < N_WRITE; p++) begin
      if (WriteEnable[p]) begin
        stage_addr[p] <= WriteAddr[p];
        stage_way[p]  <= WriteWay[p];
        stage_data[p] <= WriteData[p];
      end
    end
    if (InvEnable) begin
      inv_way  <= InvWay;
      inv_addr <= InvAddr;
    end
  end

  // ------------------------------------------------------------------
  // Commit: the invalidate is applied first, then writes from the highest
  // port down to port 0.
  // The last non-blocking assignment wins, so writes override the invalidate
  // and the lowest port index wins a conflict.
  // A reset on the commit edge drops anything staged.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (inv_en) begin
        for (int w = 0; w < NB_WAYS; w++) begin
          if (inv_way[w]) begin
            valid_q[w][inv_addr] <= 1'b0;
          end
        end
      end
      for (int p = N_WRITE - 1; p >= 0; p--) begin
        for (int w = 0; w < NB_WAYS; w++) begin
          if (stage_en[p] && stage_way[p][w]) begin
            valid_q[w][stage_addr[p]] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int p = N_WRITE - 1; p >= 0; p--) begin
        for (int w = 0; w < NB_WAYS; w++) begin
          if (stage_en[p] && stage_way[p][w]) begin
            mem[w][stage_addr[p]] <= stage_data[p];
          end
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Read address registers: each one holds its value until its port is enabled again.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      raddr_q <= '0;
    end else begin
      for (int z = 0; z < N_READ; z++) begin
        if (ReadEnable[z]) begin
          raddr_q[z] <= ReadAddr[z];
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Read outputs are combinational from the array. A held address therefore
  // follows later commits, including invalidation.
  // ------------------------------------------------------------------
  always_comb begin
    ReadValid = '0;
    ReadData  = '0;
    for (int x = 0; x < NB_WAYS; x++) begin
      for (int z = 0; z < N_READ; z++) begin
        ReadValid[x][z] = valid_q[x][raddr_q[z]];
        ReadData[x][z]  = valid_q[x][raddr_q[z]] ? mem[x][raddr_q[z]] : '0;
`ifdef SCM_WRITE_BYPASS_EN
        // Forwarding mirrors the commit priority: the invalidate first,
        // then the writes, with the lowest port applied last.
        if (inv_en && inv_way[x] && (inv_addr == raddr_q[z])) begin
          ReadValid[x][z] = 1'b0;
          ReadData[x][z]  = '0;
        end
        for (int p = N_WRITE - 1; p >= 0; p--) begin
          if (stage_en[p] && stage_way[p][x] && (stage_addr[p] == raddr_q[z])) begin
            ReadValid[x][z] = 1'b1;
            ReadData[x][z]  = stage_data[p];
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_register_file_multi_way_mw_multi_port_read.sv
// tb/tb_register_file_multi_way_mw_multi_port_read.sv - directed self-checking bench for the multi-way register file

module tb_register_file_multi_way_mw_multi_port_read;

  localparam int NB_WAYS    = 4;
  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam int N_READ     = 2;
  localparam int N_WRITE    = 2;

`ifdef SCM_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                                            clk;
  logic                                            rst;
  logic [N_READ-1:0]                               read_enable;
  logic [N_READ-1:0][ADDR_WIDTH-1:0]               read_addr;
  logic [NB_WAYS-1:0][N_READ-1:0][DATA_WIDTH-1:0]  read_data;
  logic [NB_WAYS-1:0][N_READ-1:0]                  read_valid;
  logic [N_WRITE-1:0]                              write_enable;
  logic [N_WRITE-1:0][NB_WAYS-1:0]                 write_way;
  logic [N_WRITE-1:0][ADDR_WIDTH-1:0]              write_addr;
  logic [N_WRITE-1:0][DATA_WIDTH-1:0]              write_data;
  logic                                            inv_enable;
  logic [NB_WAYS-1:0]                              inv_way;
  logic [ADDR_WIDTH-1:0]                           inv_addr;

  int n_checks;
  int n_fail;

  register_file_multi_way_mw_multi_port_read #(
    .NB_WAYS(NB_WAYS), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .N_READ(N_READ), .N_WRITE(N_WRITE)
  ) dut (
    .clk(clk), .rst(rst),
    .ReadEnable(read_enable), .ReadAddr(read_addr),
    .ReadData(read_data), .ReadValid(read_valid),
    .WriteEnable(write_enable), .WriteWay(write_way),
    .WriteAddr(write_addr), .WriteData(write_data),
    .InvEnable(inv_enable), .InvWay(inv_way), .InvAddr(inv_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    read_enable  = '0;
    write_enable = '0;
    inv_enable   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    read_addr = '0; write_way = '0; write_addr = '0; write_data = '0;
    inv_way = '0; inv_addr = '0;
    step(); step();
    rst = 1'b0;
    read_enable = 2'b11;
    read_addr[0] = 5'd3;
    read_addr[1] = 5'd3;
    step();
    idle();
    for (int x = 0; x < NB_WAYS; x++) begin
      for (int z = 0; z < N_READ; z++) begin
        n_checks++;
        if (read_valid[x][z] !== 1'b0 || read_data[x][z] !== 32'h0) begin
          n_fail++;
          $display("FAIL reset_read way%0d port%0d: valid=%b data=%h, required valid=0 data=0",
                   x, z, read_valid[x][z], read_data[x][z]);
        end
      end
    end
  endtask

  task automatic test_write_mask();
    logic exp_v;
    write_enable[0] = 1'b1;
    write_way[0]    = 4'b0101;
    write_addr[0]   = 5'd5;
    write_data[0]   = 32'hDEADBEEF;
    read_enable[0]  = 1'b1;
    read_addr[0]    = 5'd5;
    step();
    idle();
    // Cycle t+1: new data only through forwarding.
    exp_v = BYPASS;
    n_checks++;
    if (read_valid[0][0] !== exp_v) begin
      n_fail++;
      $display("FAIL write_mask_t1 way0: valid=%b, required %b", read_valid[0][0], exp_v);
    end
    step();
    for (int x = 0; x < NB_WAYS; x++) begin
      logic            ev;
      logic [31:0]     ed;
      ev = (x == 0 || x == 2);
      ed = ev ? 32'hDEADBEEF : 32'h0;
      n_checks++;
      if (read_valid[x][0] !== ev || read_data[x][0] !== ed) begin
        n_fail++;
        $display("FAIL write_mask_t2 way%0d: valid=%b data=%h, required valid=%b data=%h",
                 x, read_valid[x][0], read_data[x][0], ev, ed);
      end
    end
  endtask

  task automatic test_conflict();
    write_enable  = 2'b11;
    write_way[0]  = 4'b0010;
    write_addr[0] = 5'd7;
    write_data[0] = 32'h11;
    write_way[1]  = 4'b0110;
    write_addr[1] = 5'd7;
    write_data[1] = 32'h22;
    read_enable[1] = 1'b1;
    read_addr[1]   = 5'd7;
    step();
    idle();
    step();
    n_checks++;
    if (read_valid[1][1] !== 1'b1 || read_data[1][1] !== 32'h11) begin
      n_fail++;
      $display("FAIL conflict_way1: valid=%b data=%h, required valid=1 data=00000011",
               read_valid[1][1], read_data[1][1]);
    end
    n_checks++;
    if (read_valid[2][1] !== 1'b1 || read_data[2][1] !== 32'h22) begin
      n_fail++;
      $display("FAIL conflict_way2: valid=%b data=%h, required valid=1 data=00000022",
               read_valid[2][1], read_data[2][1]);
    end
    n_checks++;
    if (read_valid[0][1] !== 1'b0) begin
      n_fail++;
      $display("FAIL conflict_way0: valid=%b, required 0", read_valid[0][1]);
    end
  endtask

  task automatic test_invalidate();
    logic exp_v;
    write_enable[0] = 1'b1;
    write_way[0]    = 4'b0001;
    write_addr[0]   = 5'd2;
    write_data[0]   = 32'hAA;
    read_enable[0]  = 1'b1;
    read_addr[0]    = 5'd2;
    step();
    idle();
    step();
    n_checks++;
    if (read_valid[0][0] !== 1'b1 || read_data[0][0] !== 32'hAA) begin
      n_fail++;
      $display("FAIL inv_setup: valid=%b data=%h, required valid=1 data=000000aa",
               read_valid[0][0], read_data[0][0]);
    end
    // Invalidate and write the same word on the same cycle: the write wins.
    inv_enable      = 1'b1;
    inv_way         = 4'b0001;
    inv_addr        = 5'd2;
    write_enable[0] = 1'b1;
    write_data[0]   = 32'hBB;
    step();
    idle();
    step();
    n_checks++;
    if (read_valid[0][0] !== 1'b1 || read_data[0][0] !== 32'hBB) begin
      n_fail++;
      $display("FAIL inv_write_wins: valid=%b data=%h, required valid=1 data=000000bb",
               read_valid[0][0], read_data[0][0]);
    end
    // Invalidate alone. The address is held, so the read follows the commit.
    inv_enable = 1'b1;
    step();
    idle();
    exp_v = !BYPASS;
    n_checks++;
    if (read_valid[0][0] !== exp_v) begin
      n_fail++;
      $display("FAIL inv_alone_t1: valid=%b, required %b", read_valid[0][0], exp_v);
    end
    step();
    n_checks++;
    if (read_valid[0][0] !== 1'b0 || read_data[0][0] !== 32'h0) begin
      n_fail++;
      $display("FAIL inv_alone_t2: valid=%b data=%h, required valid=0 data=0",
               read_valid[0][0], read_data[0][0]);
    end
  endtask

  task automatic test_reset_pending();
    write_enable[1] = 1'b1;
    write_way[1]    = 4'b1111;
    write_addr[1]   = 5'd9;
    write_data[1]   = 32'h55;
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    read_enable    = 2'b11;
    read_addr[0]   = 5'd9;
    read_addr[1]   = 5'd5;
    step();
    idle();
    for (int k = 0; k < 2; k++) begin
      for (int x = 0; x < NB_WAYS; x++) begin
        n_checks++;
        if (read_valid[x][0] !== 1'b0 || read_data[x][0] !== 32'h0) begin
          n_fail++;
          $display("FAIL reset_pending way%0d pass%0d: valid=%b data=%h, required valid=0 data=0",
                   x, k, read_valid[x][0], read_data[x][0]);
        end
      end
      step();
    end
    n_checks++;
    if (read_valid[0][1] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clears_valid addr5: valid=%b, required 0", read_valid[0][1]);
    end
  endtask

  task automatic test_read_after_write();
    logic        exp_v;
    logic [31:0] exp_d;
    write_enable[1] = 1'b1;
    write_way[1]    = 4'b1000;
    write_addr[1]   = 5'd11;
    write_data[1]   = 32'h12345678;
    read_enable[0]  = 1'b1;
    read_addr[0]    = 5'd11;
    step();
    idle();
    exp_v = BYPASS;
    exp_d = BYPASS ? 32'h12345678 : 32'h0;
    n_checks++;
    if (read_valid[3][0] !== exp_v || read_data[3][0] !== exp_d) begin
      n_fail++;
      $display("FAIL raw_t1: valid=%b data=%h, required valid=%b data=%h",
               read_valid[3][0], read_data[3][0], exp_v, exp_d);
    end
    step();
    n_checks++;
    if (read_valid[3][0] !== 1'b1 || read_data[3][0] !== 32'h12345678) begin
      n_fail++;
      $display("FAIL raw_t2: valid=%b data=%h, required valid=1 data=12345678",
               read_valid[3][0], read_data[3][0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'hA0A0_0001;
    vals[1] = 32'hB0B0_0002;
    vals[2] = 32'hC0C0_0003;
    for (int i = 0; i < 3; i++) begin
      write_enable[0] = 1'b1;
      write_way[0]    = 4'b0001;
      write_addr[0]   = 5'(12 + i);
      write_data[0]   = vals[i];
      step();
    end
    idle();
    step();
    read_enable  = 2'b11;
    read_addr[0] = 5'd12;
    read_addr[1] = 5'd13;
    step();
    idle();
    n_checks++;
    if (read_valid[0][0] !== 1'b1 || read_data[0][0] !== vals[0]) begin
      n_fail++;
      $display("FAIL b2b_addr12: valid=%b data=%h, required valid=1 data=%h",
               read_valid[0][0], read_data[0][0], vals[0]);
    end
    n_checks++;
    if (read_valid[0][1] !== 1'b1 || read_data[0][1] !== vals[1]) begin
      n_fail++;
      $display("FAIL b2b_addr13: valid=%b data=%h, required valid=1 data=%h",
               read_valid[0][1], read_data[0][1], vals[1]);
    end
    read_enable[0] = 1'b1;
    read_addr[0]   = 5'd14;
    step();
    idle();
    n_checks++;
    if (read_valid[0][0] !== 1'b1 || read_data[0][0] !== vals[2]) begin
      n_fail++;
      $display("FAIL b2b_addr14: valid=%b data=%h, required valid=1 data=%h",
               read_valid[0][0], read_data[0][0], vals[2]);
    end
    // Port 1 keeps addr 13 without ReadEnable and must see the overwrite.
    write_enable[1] = 1'b1;
    write_way[1]    = 4'b0001;
    write_addr[1]   = 5'd13;
    write_data[1]   = 32'h0BAD_F00D;
    step();
    idle();
    step();
    n_checks++;
    if (read_valid[0][1] !== 1'b1 || read_data[0][1] !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL held_addr_tracks: valid=%b data=%h, required valid=1 data=0badf00d",
               read_valid[0][1], read_data[0][1]);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_write_mask();
    test_conflict();
    test_invalidate();
    test_reset_pending();
    test_read_after_write();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
